// File: rtl/result_write_arbiter.sv
// Round-robin arbiter sharing one frame-buffer write port among NUM_PARALLEL
// box_filter result lanes, each buffered in its own small FIFO with backpressure.
module result_write_arbiter #(
  parameter int NUM_PARALLEL      = 8,
  parameter int NUM_PARALLEL_BITS = 3,
  parameter int WIDTH_BITS        = 8,
  parameter int HEIGHT_BITS       = 8,
  parameter int FIFO_DEPTH_BITS   = 2
) (
  input  logic                                 clock,
  input  logic                                 not_reset,
  input  logic [NUM_PARALLEL-1:0]              iValid,
  input  logic [NUM_PARALLEL*WIDTH_BITS-1:0]   iCol,
  input  logic [NUM_PARALLEL*HEIGHT_BITS-1:0]  iRow,
  input  logic [NUM_PARALLEL-1:0]              iData,
  output logic [NUM_PARALLEL-1:0]              oReady,
  output logic [HEIGHT_BITS-1:0]               oX,
  output logic [WIDTH_BITS-1:0]                oY,
  output logic [2:0]                           oR,
  output logic [2:0]                           oG,
  output logic [2:0]                           oB,
  output logic                                 oWren,
  output logic [NUM_PARALLEL_BITS-1:0]         oGrant,
  output logic                                 oIdle,
  output logic [23:0]                          oWriteCount
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
  localparam int ENTRY_W = HEIGHT_BITS + WIDTH_BITS + 1;
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_FULL = DEPTH;
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE  = 1;
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = 1;
  localparam logic [NUM_PARALLEL_BITS-1:0] LANE_ONE = 1;

  // Entry layout: {row, col, data}
  logic [ENTRY_W-1:0]           mem     [NUM_PARALLEL][DEPTH];
  logic [FIFO_DEPTH_BITS-1:0]   wr_ptr  [NUM_PARALLEL];
  logic [FIFO_DEPTH_BITS-1:0]   rd_ptr  [NUM_PARALLEL];
  logic [FIFO_DEPTH_BITS:0]     count   [NUM_PARALLEL];

  logic [NUM_PARALLEL-1:0]      push;
  logic [NUM_PARALLEL-1:0]      pop;
  logic [NUM_PARALLEL-1:0]      nonempty;

  logic [NUM_PARALLEL_BITS-1:0] rr_ptr;
  logic [NUM_PARALLEL_BITS-1:0] search_idx;
  logic [NUM_PARALLEL_BITS-1:0] grant_idx_p0;
  logic                         grant_valid_p0;
  logic [ENTRY_W-1:0]           head_p0;

  always_comb begin
    for (int k = 0; k < NUM_PARALLEL; k++) begin
      oReady[k]   = (count[k] != CNT_FULL);
      nonempty[k] = (count[k] != '0);
      push[k]     = iValid[k] && oReady[k];
    end
  end

  // Scan offsets from farthest to nearest so the nearest non-empty lane
  // at or above rr_ptr is the one left standing.
  always_comb begin
    grant_valid_p0 = 1'b0;
    grant_idx_p0   = rr_ptr;
    search_idx     = rr_ptr;
    for (int i = NUM_PARALLEL - 1; i >= 0; i--) begin
      search_idx = rr_ptr + NUM_PARALLEL_BITS'(i);
      if (nonempty[search_idx]) begin
        grant_valid_p0 = 1'b1;
        grant_idx_p0   = search_idx;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PARALLEL; k++) begin
      pop[k] = grant_valid_p0 && (grant_idx_p0 == NUM_PARALLEL_BITS'(k));
    end
  end

  assign head_p0 = mem[grant_idx_p0][rd_ptr[grant_idx_p0]];

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_PARALLEL; k++) begin
      if (push[k]) begin
        mem[k][wr_ptr[k]] <= {iRow[k*HEIGHT_BITS +: HEIGHT_BITS],
                              iCol[k*WIDTH_BITS +: WIDTH_BITS],
                              iData[k]};
      end
    end
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      for (int k = 0; k < NUM_PARALLEL; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PARALLEL; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CNT_ONE;
          2'b01:   count[k] <= count[k] - CNT_ONE;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      rr_ptr <= '0;
    end else if (grant_valid_p0) begin
      rr_ptr <= grant_idx_p0 + LANE_ONE;
    end
  end

  // ---- stage p0 -> output register ----
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      oWren       <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
      oGrant      <= '0;
      oWriteCount <= '0;
    end else begin
      oWren <= grant_valid_p0;
      if (grant_valid_p0) begin
        oX          <= head_p0[ENTRY_W-1 -: HEIGHT_BITS];
        oY          <= head_p0[WIDTH_BITS:1];
        oR          <= {3{head_p0[0]}};
        oG          <= {3{head_p0[0]}};
        oB          <= {3{head_p0[0]}};
        oGrant      <= grant_idx_p0;
        oWriteCount <= oWriteCount + 24'd1;
      end
    end
  end

  assign oIdle = ~(|nonempty) && !oWren;

endmodule
